// File: rtl/uart_bus_responder.sv
// Memory-mapped 8N1 UART responder: TXD/RXD/CON word registers on the MEM-stage load/store bus.
// Define UART_RX_FIFO_EN for a 4-entry RX FIFO; otherwise RX uses a single holding register.
module uart_bus_responder #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        Mem_rd,
  input  logic        Mem_wr,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [29:0]   BASE_W    = BASE_ADDR[31:2];

  logic hit_txd, hit_rxd, hit_con;
  assign hit_txd = (addr[31:2] == BASE_W);
  assign hit_rxd = (addr[31:2] == BASE_W + 30'd1);
  assign hit_con = (addr[31:2] == BASE_W + 30'd2);

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], Write_data[31:8]};

  // ---------------------------------------------------------------- TX
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  tx_state_e     tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_idx_q;
  logic [7:0]    tx_byte_q;
  logic          uart_tx_q;
  logic          tx_bit_end;
  logic          tx_busy;

  assign tx_bit_end = (tx_cnt_q == BIT_LAST);
  assign tx_busy    = (tx_state_q != TX_IDLE);
  assign uart_tx    = uart_tx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_byte_q  <= '0;
      uart_tx_q  <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_cnt_q <= '0;
          if (Mem_wr && hit_txd) begin
            tx_byte_q  <= Write_data[7:0];
            tx_state_q <= TX_START;
            uart_tx_q  <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_state_q <= TX_DATA;
            uart_tx_q  <= tx_byte_q[0];
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_cnt_q <= '0;
            if (tx_idx_q == 3'd7) begin
              tx_state_q <= TX_STOP;
              uart_tx_q  <= 1'b1;
            end else begin
              tx_idx_q  <= tx_idx_q + 3'd1;
              uart_tx_q <= tx_byte_q[tx_idx_q + 3'd1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            tx_cnt_q   <= '0;
            tx_state_q <= TX_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: begin
          tx_state_q <= TX_IDLE;
          uart_tx_q  <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e     rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_idx_q;
  logic [7:0]    rx_shift_q;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic          rx_push_q, rx_ferr_q;

  // The synchronizer free-runs through reset so it always tracks the pin.
  always_ff @(posedge clk) begin
    rx_meta_q <= uart_rx;
    rx_sync_q <= rx_meta_q;
  end

  // rx_prev_q resets low so a line held low across reset is not taken as a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_prev_q  <= 1'b0;
      rx_push_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_prev_q <= rx_sync_q;
      rx_push_q <= 1'b0;
      rx_ferr_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          if (rx_prev_q && !rx_sync_q) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            if (rx_idx_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_idx_q   <= rx_idx_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            rx_push_q  <= rx_sync_q;
            rx_ferr_q  <= !rx_sync_q;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX buffer
  logic       rx_valid;
  logic       rx_full;
  logic       rx_pop;
  logic       rx_push_ok;
  logic [2:0] rx_count;
  logic [7:0] rx_head;

  assign rx_pop     = Mem_rd && hit_rxd && rx_valid;
  assign rx_push_ok = rx_push_q && (!rx_full || rx_pop);

`ifdef UART_RX_FIFO_EN
  logic [7:0] fifo_q [4];
  logic [1:0] wptr_q, rptr_q;
  logic [2:0] cnt_q;

  assign rx_full  = (cnt_q == 3'd4);
  assign rx_valid = (cnt_q != 3'd0);
  assign rx_count = cnt_q;
  assign rx_head  = rx_valid ? fifo_q[rptr_q] : '0;

  always_ff @(posedge clk) begin
    if (rx_push_ok) fifo_q[wptr_q] <= rx_shift_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (rx_push_ok) wptr_q <= wptr_q + 2'd1;
      if (rx_pop)     rptr_q <= rptr_q + 2'd1;
      case ({rx_push_ok, rx_pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
`else
  logic [7:0] hold_q;
  logic       hold_v_q;

  assign rx_full  = hold_v_q;
  assign rx_valid = hold_v_q;
  assign rx_count = {2'b00, hold_v_q};
  assign rx_head  = hold_v_q ? hold_q : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q   <= '0;
      hold_v_q <= 1'b0;
    end else if (rx_push_ok) begin
      hold_q   <= rx_shift_q;
      hold_v_q <= 1'b1;
    end else if (rx_pop) begin
      hold_v_q <= 1'b0;
    end
  end
`endif

  // ---------------------------------------------------------------- flags
  logic ovr_q, ovr_d, ferr_q, ferr_d;
  logic con_wr;
  logic ovr_set;

  assign con_wr  = Mem_wr && hit_con;
  assign ovr_set = rx_push_q && rx_full && !rx_pop;

  // A hardware set on the same edge as a W1C clear keeps the flag set.
  always_comb begin
    ovr_d  = ovr_set   | (ovr_q  & ~(con_wr & Write_data[2]));
    ferr_d = rx_ferr_q | (ferr_q & ~(con_wr & Write_data[3]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
    end
  end

  // ---------------------------------------------------------------- read mux
  always_comb begin
    Read_data = '0;
    if (Mem_rd) begin
      if (hit_txd)      Read_data = {24'b0, tx_byte_q};
      else if (hit_rxd) Read_data = {24'b0, rx_head};
      else if (hit_con) Read_data = {24'b0, rx_count, 1'b0, ferr_q, ovr_q, rx_valid, tx_busy};
    end
  end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Scoreboard bench for uart_bus_responder at 16 clocks per bit (honours UART_RX_FIFO_EN).
module tb_uart_bus_responder;

  localparam int unsigned CPB  = 16;
  localparam logic [31:0] BASE = 32'h4000_0018;
  localparam logic [31:0] A_TXD = BASE;
  localparam logic [31:0] A_RXD = BASE + 32'd4;
  localparam logic [31:0] A_CON = BASE + 32'd8;
`ifdef UART_RX_FIFO_EN
  localparam int RX_DEPTH = 4;
`else
  localparam int RX_DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        Mem_rd, Mem_wr;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic        uart_rx;
  logic        uart_tx;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] tx_exp_q [$];
  logic [7:0] rx_exp_q [$];
  int         rx_model_cnt = 0;
  logic       rx_model_ovr = 1'b0;
  logic       rx_model_ferr = 1'b0;

  uart_bus_responder #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .Mem_rd     (Mem_rd),
    .Mem_wr     (Mem_wr),
    .Write_data (Write_data),
    .Read_data  (Read_data),
    .uart_rx    (uart_rx),
    .uart_tx    (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; Write_data = d; Mem_wr = 1'b1;
    @(posedge clk); #1;
    Mem_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; Mem_rd = 1'b1;
    #1 d = Read_data;
    @(posedge clk); #1;
    Mem_rd = 1'b0;
  endtask

  // Combinational look without crossing a clock edge.
  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    addr = a; Mem_rd = 1'b1;
    #1 d = Read_data;
    Mem_rd = 1'b0;
  endtask

  function automatic logic [31:0] con_model();
    return (32'(rx_model_cnt) << 5) | (rx_model_ferr ? 32'h8 : 32'h0) |
           (rx_model_ovr ? 32'h4 : 32'h0) | (rx_model_cnt != 0 ? 32'h2 : 32'h0);
  endfunction

  task automatic tx_write(input logic [7:0] b, input logic accepted);
    if (accepted) tx_exp_q.push_back(b);
    bus_write(A_TXD, {24'h0, b});
  endtask

  // Called 'elapsed' edges after the accepting TXD write edge; samples every bit mid-way.
  task automatic tx_check_frame(input int unsigned elapsed);
    logic [7:0]  exp;
    logic [9:0]  bits;
    logic [31:0] d;
    if (tx_exp_q.size() == 0) begin
      check_eq("tx_sb_nonempty", 32'd0, 32'd1);
      return;
    end
    exp  = tx_exp_q.pop_front();
    bits = {1'b1, exp, 1'b0};
    tick(8 - elapsed);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick(CPB);
      check_eq($sformatf("tx_bit%0d_of_%02h", i, exp), {31'b0, uart_tx}, {31'b0, bits[i]});
    end
    tick(7);
    peek(A_CON, d);
    check_eq("tx_busy_at_159", {31'b0, d[0]}, 32'd1);
    tick(1);
    peek(A_CON, d);
    check_eq("tx_busy_at_160", {31'b0, d[0]}, 32'd0);
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    if (stop) begin
      if (rx_model_cnt < RX_DEPTH) begin
        rx_exp_q.push_back(b);
        rx_model_cnt++;
      end else begin
        rx_model_ovr = 1'b1;
      end
    end else begin
      rx_model_ferr = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      tick(CPB);
    end
    uart_rx = 1'b1;
    tick(4);
  endtask

  task automatic rx_read_check(input string tag);
    logic [31:0] d, exp;
    exp = '0;
    if (rx_exp_q.size() > 0) begin
      exp = {24'h0, rx_exp_q.pop_front()};
      rx_model_cnt--;
    end
    bus_read(A_RXD, d);
    check_eq(tag, d, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  ov_bytes [5];
    ov_bytes = '{8'hC3, 8'h7E, 8'h21, 8'h9D, 8'h44};

    reset = 1'b1; Mem_rd = 1'b0; Mem_wr = 1'b0; addr = '0; Write_data = '0; uart_rx = 1'b1;
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;

    check_eq("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
    peek(A_CON, d); check_eq("rst_con", d, 32'h0);
    peek(A_TXD, d); check_eq("rst_txd", d, 32'h0);
    peek(A_RXD, d); check_eq("rst_rxd", d, 32'h0);
    tick(2);

    tx_write(8'hA5, 1'b1);
    check_eq("tx_start_low", {31'b0, uart_tx}, 32'd0);
    peek(A_CON, d); check_eq("tx_con_busy", d, 32'h1);
    addr = A_CON; Mem_rd = 1'b0;
    #1 check_eq("rd_idle_zero", Read_data, 32'h0);
    addr = BASE + 32'd12; Mem_rd = 1'b1;
    #1 check_eq("rd_miss_zero", Read_data, 32'h0);
    Mem_rd = 1'b0;
    tx_check_frame(0);
    tick(2);

    tx_write(8'h3C, 1'b1);
    tick(4);
    tx_write(8'hFF, 1'b0);
    peek(A_TXD, d); check_eq("txd_readback", d, 32'h3C);
    tx_check_frame(5);
    tick(2);

    uart_send(8'h5A, 1'b1);
    peek(A_CON, d); check_eq("rx_con_valid", d, con_model());
    rx_read_check("rx_5a");
    peek(A_CON, d); check_eq("rx_con_after_pop", d, con_model());

    uart_send(8'h11, 1'b0);
    peek(A_CON, d); check_eq("ferr_con", d, con_model());
    bus_write(A_CON, 32'h8); rx_model_ferr = 1'b0;
    peek(A_CON, d); check_eq("ferr_w1c", d, con_model());
    rx_read_check("ferr_no_byte");

    for (int i = 0; i < RX_DEPTH + 1; i++) uart_send(ov_bytes[i], 1'b1);
    peek(A_CON, d); check_eq("ovr_con", d, con_model());
    for (int i = 0; i < RX_DEPTH; i++) rx_read_check($sformatf("ovr_keep%0d", i));
    peek(A_CON, d); check_eq("ovr_con_drained", d, con_model());
    bus_write(A_CON, 32'h4); rx_model_ovr = 1'b0;
    peek(A_CON, d); check_eq("ovr_w1c", d, con_model());

    tx_write(8'h55, 1'b0);
    tick(39);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_eq("rst_mid_tx_line", {31'b0, uart_tx}, 32'd1);
    peek(A_CON, d); check_eq("rst_mid_tx_con", d, 32'h0);
    peek(A_TXD, d); check_eq("rst_mid_tx_txd", d, 32'h0);
    tick(3);

    uart_rx = 1'b0;
    tick(4);
    uart_rx = 1'b1;
    tick(40);
    peek(A_CON, d); check_eq("false_start_con", d, con_model());
    uart_send(8'h96, 1'b1);
    rx_read_check("rx_after_false_start");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
